fft_bank_sched: RTL and testbench

FFT_BANK_SCHED -- requirements
Module: fft_bank_sched

---
 rtl/fft_bank_sched_pkg.sv | 5 +
 rtl/fft_bank_sched_if.sv | 11 +
 rtl/fft_bank_loader.sv | 45 ++++
 rtl/fft_bank_sched.sv | 55 +++++
 tb/tb_fft_bank_sched.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/fft_bank_sched_pkg.sv
// fft_bank_sched_pkg: bank and scheduler state encodings shared by the scheduler files
package fft_bank_sched_pkg;
    typedef enum logic [1:0] {FREE, FILLING, FULL, BUSY} bank_t;
    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN} sched_t;
endpackage

// File: rtl/fft_bank_sched_if.sv
// fft_bank_sched_if: loader/FFT-controller signals of the bank scheduler
interface fft_bank_sched_if #(parameter int SIZE = 4);
    logic in_valid, in_ready, ld_we, ld_bank;
    logic fft_start, fft_bank, fft_done, err_timeout;
    logic [SIZE-1:0] ld_addr;
    logic [1:0] bank_full;
    modport master(output in_valid, fft_done,
                   input in_ready, ld_we, ld_addr, ld_bank, fft_start, fft_bank, bank_full, err_timeout);
    modport slave(input in_valid, fft_done,
                  output in_ready, ld_we, ld_addr, ld_bank, fft_start, fft_bank, bank_full, err_timeout);
endinterface

// File: rtl/fft_bank_loader.sv
// fft_bank_loader: per-bank state, load address and bank choice for the sample loader
module fft_bank_loader
    import fft_bank_sched_pkg::*;
#(
    parameter int N = 16,
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            take,
    input  logic            take_bank,
    input  logic            rel,
    input  logic            rel_bank,
    output logic            in_ready,
    output logic            ld_we,
    output logic [SIZE-1:0] ld_addr,
    output logic            ld_bank,
    output logic [1:0]      bank_full,
    output logic            full_evt
);
    bank_t st [2];
    logic last;
    always_comb begin
        ld_bank = (st[0] == FILLING) ? 1'b0 : (st[1] == FILLING) ? 1'b1 : (st[0] == FREE) ? 1'b0 : 1'b1;
        in_ready = rst_n && (st[ld_bank] == FILLING || st[ld_bank] == FREE);
        ld_we = in_valid && in_ready;
        last = ld_addr == SIZE'(N - 1);
        full_evt = ld_we && last;
        bank_full = {st[1] == FULL, st[0] == FULL};
    end
    // load, claim and release never target the same bank in one cycle
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ld_addr <= '0;
            st[0] <= FREE;
            st[1] <= FREE;
        end else begin
            if (ld_we) ld_addr <= last ? '0 : ld_addr + 1'b1;
            for (int b = 0; b < 2; b++)
                if (ld_we && ld_bank == 1'(b)) st[b] <= last ? FULL : FILLING;
                else if (take && take_bank == 1'(b)) st[b] <= BUSY;
                else if (rel && rel_bank == 1'(b)) st[b] <= FREE;
        end
endmodule

// File: rtl/fft_bank_sched.sv
// fft_bank_sched: ping-pong bank scheduler between sample loader and FFT controller
// Define FFT_BANK_SCHED_WDOG_EN to add an S_RUN watchdog of TIMEOUT_CYC cycles.
module fft_bank_sched
    import fft_bank_sched_pkg::*;
#(
    parameter int N = 16,
    parameter int SIZE = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input logic clk,
    input logic rst_n,
    fft_bank_sched_if.slave bus
);
    sched_t state, state_nx;
    logic [1:0] full;
    logic full_evt, order, fbank, sel, take, rel, timeout;
    fft_bank_loader #(.N(N), .SIZE(SIZE)) u_loader (
        .clk(clk), .rst_n(rst_n), .in_valid(bus.in_valid),
        .take(take), .take_bank(fbank), .rel(rel), .rel_bank(fbank),
        .in_ready(bus.in_ready), .ld_we(bus.ld_we), .ld_addr(bus.ld_addr),
        .ld_bank(bus.ld_bank), .bank_full(full), .full_evt(full_evt)
    );
    always_comb begin
        sel = (full == 2'b11) ? order : full[1];
        take = state == S_START;
        rel = state == S_RUN && (bus.fft_done || timeout);
        state_nx = (state == S_IDLE && |full) ? S_START : take ? S_RUN : rel ? S_IDLE : state;
    end
    // order remembers the older FULL bank when the other one fills later
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= S_IDLE;
            fbank <= 1'b0;
            order <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && |full) fbank <= sel;
            if (full_evt && !full[~bus.ld_bank]) order <= bus.ld_bank;
        end
    assign bus.fft_start = take;
    assign bus.fft_bank = fbank;
    assign bus.bank_full = full;
`ifdef FFT_BANK_SCHED_WDOG_EN
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    logic [WDW-1:0] wd_cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) wd_cnt <= '0;
        else wd_cnt <= (state == S_RUN) ? wd_cnt + 1'b1 : '0;
    assign timeout = state == S_RUN && wd_cnt == WDW'(TIMEOUT_CYC);
    assign bus.err_timeout = timeout && !bus.fft_done;
`else
    assign timeout = 1'b0;
    assign bus.err_timeout = (TIMEOUT_CYC < 0);
`endif
endmodule

// File: tb/tb_fft_bank_sched.sv
// tb_fft_bank_sched: directed bench with a bank/queue model checked on every cycle
module tb_fft_bank_sched;
    localparam int N = 16;
`ifdef FFT_BANK_SCHED_WDOG_EN
    localparam int TO = 8;
`else
    localparam int TO = 4096;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_pass = 0, n_total = 0;
    int m_st [2];
    int m_addr, m_phase, m_fbank, m_run;
    int q[$];
    fft_bank_sched_if #(.SIZE(4)) bus ();
    fft_bank_sched #(.N(N), .SIZE(4), .TIMEOUT_CYC(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic int cur_bank();
        if (m_st[0] == 1) return 0;
        if (m_st[1] == 1) return 1;
        if (m_st[0] == 0) return 0;
        if (m_st[1] == 0) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_st[0] = 0; m_st[1] = 0;
        m_addr = 0; m_phase = 0; m_fbank = 0; m_run = 0;
        q.delete();
    endtask

    function automatic int exp_err(input bit d);
`ifdef FFT_BANK_SCHED_WDOG_EN
        return int'(m_phase == 2 && m_run == TO && !d);
`else
        return 0 & int'(d);
`endif
    endfunction

    task automatic compare(input bit v, input bit d);
        int c;
        c = cur_bank();
        chk("in_ready", int'(bus.in_ready), int'(c >= 0));
        chk("ld_we", int'(bus.ld_we), int'(v && c >= 0));
        if (c >= 0) chk("ld_bank", int'(bus.ld_bank), c);
        chk("ld_addr", int'(bus.ld_addr), m_addr);
        chk("bank_full", int'(bus.bank_full), 2 * int'(m_st[1] == 2) + int'(m_st[0] == 2));
        chk("fft_start", int'(bus.fft_start), int'(m_phase == 1));
        chk("fft_bank", int'(bus.fft_bank), m_fbank);
        chk("err_timeout", int'(bus.err_timeout), exp_err(d));
    endtask

    // phase: 0 idle, 1 start pulse, 2 controller running; q lists FULL banks oldest first
    task automatic model_step(input bit v, input bit d);
        int c;
        bit we, to;
        c = cur_bank();
        we = v && c >= 0;
`ifdef FFT_BANK_SCHED_WDOG_EN
        to = m_phase == 2 && m_run == TO;
`else
        to = 1'b0;
`endif
        if (m_phase == 0 && q.size() > 0) begin
            m_phase = 1; m_fbank = q[0];
        end else if (m_phase == 1) begin
            m_phase = 2; m_st[m_fbank] = 3; q.delete(0); m_run = 0;
        end else if (m_phase == 2 && (d || to)) begin
            m_st[m_fbank] = 0; m_phase = 0;
        end else if (m_phase == 2) m_run++;
        if (we) begin
            if (m_addr == N - 1) begin
                m_st[c] = 2; q.push_back(c); m_addr = 0;
            end else begin
                m_st[c] = 1; m_addr++;
            end
        end
    endtask

    task automatic tick(input bit v, input bit d);
        bus.in_valid = v;
        bus.fft_done = d;
        @(negedge clk);
        compare(v, d);
        @(posedge clk);
        model_step(v, d);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.fft_done = 1'b0;
        @(negedge clk);
        chk("rst ld_we", int'(bus.ld_we), 0);
        chk("rst ld_addr", int'(bus.ld_addr), 0);
        chk("rst ld_bank", int'(bus.ld_bank), 0);
        chk("rst fft_start", int'(bus.fft_start), 0);
        chk("rst fft_bank", int'(bus.fft_bank), 0);
        chk("rst bank_full", int'(bus.bank_full), 0);
        chk("rst err_timeout", int'(bus.err_timeout), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst in_ready", int'(bus.in_ready), 1);
    endtask

    initial begin
        model_reset();
        // single bank fill and start latency
        do_reset();
        repeat (N) tick(1'b1, 1'b0);
        chk("t1 bank_full", int'(bus.bank_full), 1);
        chk("t1 ld_addr", int'(bus.ld_addr), 0);
        chk("t1 in_ready", int'(bus.in_ready), 1);
        chk("t1 ld_bank", int'(bus.ld_bank), 1);
        chk("t1 start early", int'(bus.fft_start), 0);
        tick(1'b1, 1'b0);
        chk("t1 fft_start", int'(bus.fft_start), 1);
        chk("t1 fft_bank", int'(bus.fft_bank), 0);
        // both banks loaded while the controller holds bank0
        do_reset();
        repeat (2 * N) tick(1'b1, 1'b0);
        chk("t2 bank_full", int'(bus.bank_full), 2);
        chk("t2 in_ready", int'(bus.in_ready), 0);
        repeat (3) tick(1'b1, 1'b0);
        chk("t2 addr held", int'(bus.ld_addr), 0);
        tick(1'b0, 1'b1);
        chk("t2 in_ready after done", int'(bus.in_ready), 1);
        chk("t2 no start yet", int'(bus.fft_start), 0);
        tick(1'b0, 1'b0);
        chk("t2 fft_start", int'(bus.fft_start), 1);
        chk("t2 fft_bank", int'(bus.fft_bank), 1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        // fft_done while idle is ignored
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        chk("t3 bank_full", int'(bus.bank_full), 0);
        chk("t3 fft_start", int'(bus.fft_start), 0);
        chk("t3 fft_bank", int'(bus.fft_bank), 1);
        // partial load discarded by reset
        repeat (7) tick(1'b1, 1'b0);
        chk("t4 ld_addr", int'(bus.ld_addr), 7);
        do_reset();
        chk("t4 restart addr", int'(bus.ld_addr), 0);
        chk("t4 restart bank", int'(bus.ld_bank), 0);
        tick(1'b1, 1'b0);
        chk("t4 addr step", int'(bus.ld_addr), 1);
        // done frees bank0 on the same edge bank1 fills
        do_reset();
        repeat (2 * N - 1) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        chk("t5 bank_full", int'(bus.bank_full), 2);
        chk("t5 in_ready", int'(bus.in_ready), 1);
        chk("t5 ld_bank", int'(bus.ld_bank), 0);
        tick(1'b0, 1'b0);
        chk("t5 fft_start", int'(bus.fft_start), 1);
        chk("t5 fft_bank", int'(bus.fft_bank), 1);
        tick(1'b0, 1'b0);
        // controller never answers
`ifdef FFT_BANK_SCHED_WDOG_EN
        repeat (TO) tick(1'b0, 1'b0);
        chk("t6 err_timeout", int'(bus.err_timeout), 1);
        tick(1'b0, 1'b0);
        chk("t6 err cleared", int'(bus.err_timeout), 0);
        chk("t6 bank_full", int'(bus.bank_full), 0);
        chk("t6 in_ready", int'(bus.in_ready), 1);
        tick(1'b0, 1'b0);
        chk("t6 no restart", int'(bus.fft_start), 0);
`else
        repeat (10000) tick(1'b0, 1'b0);
        chk("t6 err_timeout", int'(bus.err_timeout), 0);
        chk("t6 still busy", int'(bus.in_ready), 1);
        chk("t6 fft_bank", int'(bus.fft_bank), 1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
